// File: rtl/lc3_mem_pkg.sv
// Shared types and default widths for the LC-3 memory controller.
package lc3_mem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word RAM with registered read; contents survive reset.
module lc3_mem_array
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: one request at a time with wait states, range check,
// valid/ready response, and a debug port that shares the array when idle.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              dbg_en,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_busy
);

    localparam int unsigned MEM_AW = clog2_min1(DEPTH);
    localparam int unsigned CNT_W  = clog2_min1(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    // Full-width unsigned compare, no wrap-around.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_acc_ph;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_we;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic                r_dbg_busy;
    logic                r_dbg_fresh;
    logic                r_dbg_oor;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_accept;
    logic                w_mar_ok;
    logic                w_dbg_ok;
    logic                w_dbg_in_range;
    logic                w_mem_en;
    logic                w_mem_we;
    logic [MEM_AW-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic [DATA_W-1:0]   w_dbg_rdata;

    assign w_accept       = r_req_ready & req_valid;
    assign w_mar_ok       = in_range(r_mar);
    assign w_dbg_in_range = in_range(dbg_addr);
    assign w_dbg_ok       = (r_state == IDLE) & ~req_valid & dbg_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ACCESS spans the array cycle plus the capture of its registered read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_wait_cnt == '0) w_state_nxt = ACCESS;
            ACCESS:  if (r_acc_ph) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single array port: core access in ACCESS, otherwise an honoured debug access.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mar[MEM_AW-1:0];
        w_mem_wdata = r_mdr;
        if ((r_state == ACCESS) && !r_acc_ph) begin
            w_mem_en = w_mar_ok;
            w_mem_we = r_we;
        end else if (w_dbg_ok && w_dbg_in_range) begin
            w_mem_en    = 1'b1;
            w_mem_we    = dbg_we;
            w_mem_addr  = dbg_addr[MEM_AW-1:0];
            w_mem_wdata = dbg_wdata;
        end
    end

    lc3_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Right after a debug read the array register is shown; afterwards the value is held.
    assign w_dbg_rdata = r_dbg_fresh ? (r_dbg_oor ? '0 : w_mem_rdata) : r_dbg_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_acc_ph    <= 1'b0;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_we        <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_dbg_busy  <= 1'b0;
            r_dbg_fresh <= 1'b0;
            r_dbg_oor   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_acc_ph    <= (r_state == ACCESS) && !r_acc_ph;

            if (w_accept) begin
                r_mar      <= req_addr;
                r_mdr      <= req_wdata;
                r_we       <= req_we;
                r_wait_cnt <= WAIT_LOAD;
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
            end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end

            if ((r_state == ACCESS) && !r_acc_ph) begin
                r_rsp_err <= !w_mar_ok;
            end
            if ((r_state == ACCESS) && r_acc_ph) begin
                r_rsp_data <= (!r_we && w_mar_ok) ? w_mem_rdata : '0;
            end

            r_dbg_busy  <= dbg_en && !w_dbg_ok;
            r_dbg_fresh <= w_dbg_ok && !dbg_we;
            if (w_dbg_ok && !dbg_we) begin
                r_dbg_oor <= !w_dbg_in_range;
            end
            r_dbg_rdata <= w_dbg_rdata;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign dbg_rdata = w_dbg_rdata;
    assign dbg_busy  = r_dbg_busy;

endmodule
